// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush controller: state encoding,
// register-index constants, bubble-count limits and the load-use hazard check.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1
    } ctrl_state_e;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int LUB_MIN = 1;
    localparam int LUB_MAX = 3;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic [4:0] rs1,
        input logic       rs1Used,
        input logic [4:0] rs2,
        input logic       rs2Used,
        input logic [4:0] exRd,
        input logic       exMemRead,
        input logic       exRegWrite
    );
        logic match1;
        logic match2;
        match1 = rs1Used && (rs1 == exRd);
        match2 = rs2Used && (rs2 == exRd);
        return exMemRead && exRegWrite && (exRd != ZERO_REG) && (match1 || match2);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a synchronous
// clear that takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;
    assign o_count  = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Per-cycle stall/flush sequencer: freeze on memory busywait, flush on taken
// branch, and insert a fixed number of bubbles for each load-use hazard.
module hazard_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_reg_write_en,
    input  logic             i_branch_taken,
    input  logic             i_imem_busywait,
    input  logic             i_dmem_busywait,
    input  logic             i_cnt_clear,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_id_ex_stall,
    output logic             o_ex_mem_stall,
    output logic             o_mem_wb_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic [1:0]       o_ctrl_state,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    // Out-of-range settings are clamped so the bubble counter width stays valid.
    localparam int LUB = (LOAD_USE_BUBBLES < LUB_MIN) ? LUB_MIN :
                         (LOAD_USE_BUBBLES > LUB_MAX) ? LUB_MAX : LOAD_USE_BUBBLES;
    localparam logic [1:0] LU_EXTRA = 2'(LUB - 1);

    ctrl_state_e r_state;
    logic [1:0]  r_lu_cnt;

    ctrl_state_e w_next_state;
    logic [1:0]  w_next_lu_cnt;
    logic        w_haz;
    logic        w_frz;
    logic        w_stall_inc;
    logic        w_flush_inc;

    assign w_haz = load_use_hazard(i_id_rs1, i_id_rs1_used, i_id_rs2, i_id_rs2_used,
                                   i_ex_rd, i_ex_mem_read, i_ex_reg_write_en);
    assign w_frz = i_imem_busywait | i_dmem_busywait;

    assign o_ctrl_state = r_state;

    always_comb begin
        o_pc_stall     = 1'b0;
        o_if_id_stall  = 1'b0;
        o_id_ex_stall  = 1'b0;
        o_ex_mem_stall = 1'b0;
        o_mem_wb_stall = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        w_next_state   = r_state;
        w_next_lu_cnt  = r_lu_cnt;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;

        if (!i_reset) begin
            // Bubbles flow in while reset is held so the pipeline starts clean.
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
        end else if (w_frz) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            o_mem_wb_stall = 1'b1;
            w_stall_inc    = 1'b1;
        end else if (i_branch_taken) begin
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            w_next_state  = ST_RUN;
            w_next_lu_cnt = 2'd0;
            w_flush_inc   = 1'b1;
        end else if ((r_state == ST_RUN && w_haz) || r_state == ST_LU_STALL) begin
            o_pc_stall    = 1'b1;
            o_if_id_stall = 1'b1;
            o_id_ex_flush = 1'b1;
            w_stall_inc   = 1'b1;
            if (r_state == ST_RUN) begin
                if (LUB > 1) begin
                    w_next_state  = ST_LU_STALL;
                    w_next_lu_cnt = LU_EXTRA;
                end
            end else if (r_lu_cnt == 2'd1) begin
                w_next_state  = ST_RUN;
                w_next_lu_cnt = 2'd0;
            end else begin
                w_next_lu_cnt = r_lu_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= ST_RUN;
            r_lu_cnt <= 2'd0;
        end else begin
            r_state  <= w_next_state;
            r_lu_cnt <= w_next_lu_cnt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_cnt_clear),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_cnt_clear),
        .i_inc   (w_flush_inc),
        .o_count (o_flush_count)
    );

endmodule
